// File: rtl/vx_raster_stamp_packer.sv
// Packs a serial stream of raster stamps into NUM_LANES-wide bus requests.
// A stream terminator flushes the partial packet; afterwards every request gets a done packet.
module vx_raster_stamp_packer #(
  parameter int NUM_LANES = 4,
  parameter int STAMP_W   = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [STAMP_W-1:0]             in_stamp,
  input  logic                           in_last,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [NUM_LANES*STAMP_W-1:0]   req_stamps,
  output logic [NUM_LANES-1:0]           req_lane_mask,
  output logic                           req_done
);

  localparam int CNT_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SLOTS  = (NUM_LANES > 1) ? NUM_LANES - 1 : 1;
  localparam int SIDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_LANES - 1);

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt_p0;
  logic [STAMP_W-1:0]             slot_p0 [SLOTS];
  logic                           vld_p1;
  logic                           last_p1;
  logic [NUM_LANES-1:0]           mask_p1;
  logic [NUM_LANES*STAMP_W-1:0]   stamps_p1;

  logic [NUM_LANES*STAMP_W-1:0]   next_stamps;
  logic [NUM_LANES-1:0]           next_mask;
  logic                           completing;
  logic                           accept;
  logic                           pop;
  logic                           load;

  assign completing = (cnt_p0 == CNT_MAX) || in_last;
  assign in_ready   = (state == ST_RUN) && (!completing || !vld_p1 || req_ready);
  assign accept     = in_valid && in_ready;
  assign load       = accept && completing;
  assign pop        = req_valid && req_ready;

  // Lanes below cnt come from the fill buffer, lane cnt is the incoming stamp, the rest are zero.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    if (g < NUM_LANES - 1) begin : g_buf
      assign next_stamps[g*STAMP_W +: STAMP_W] =
        (CNT_W'(g) == cnt_p0) ? in_stamp :
        (CNT_W'(g) <  cnt_p0) ? slot_p0[g] : '0;
    end else begin : g_top
      assign next_stamps[g*STAMP_W +: STAMP_W] = (CNT_W'(g) == cnt_p0) ? in_stamp : '0;
    end
    assign next_mask[g] = (CNT_W'(g) <= cnt_p0);
  end

  // Stage p0 -> p1: fill buffer and packet register data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept && !completing) begin
      slot_p0[cnt_p0[SIDX_W-1:0]] <= in_stamp;
    end
    if (load) begin
      stamps_p1 <= next_stamps;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      cnt_p0  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      mask_p1 <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (load) begin
            vld_p1  <= 1'b1;
            last_p1 <= in_last;
            mask_p1 <= next_mask;
            cnt_p0  <= '0;
          end else begin
            if (accept) begin
              cnt_p0 <= cnt_p0 + 1'b1;
            end
            if (pop) begin
              vld_p1 <= 1'b0;
            end
          end
          // A terminating pop cannot overlap a load: in_last has already been consumed.
          if (pop && last_p1) begin
            state   <= ST_DONE;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
          end
        end
        ST_DONE: begin
          if (start) begin
            state  <= ST_RUN;
            cnt_p0 <= '0;
            vld_p1 <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign req_valid     = (state == ST_DONE) || vld_p1;
  assign req_done      = (state == ST_DONE);
  assign req_lane_mask = vld_p1 ? mask_p1 : '0;
  assign req_stamps    = vld_p1 ? stamps_p1 : '0;

endmodule

// File: tb/tb_vx_raster_stamp_packer.sv
// Bench for vx_raster_stamp_packer: 4-lane instance against a packet scoreboard, plus a 1-lane instance.
module tb_vx_raster_stamp_packer;

  localparam int NL = 4;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic req_ready = 1'b1;
  logic [SW-1:0] in_stamp = '0;
  logic in_ready, req_valid, req_done;
  logic [NL*SW-1:0] req_stamps;
  logic [NL-1:0] req_lane_mask;

  logic b_in_valid = 1'b0;
  logic b_in_last = 1'b0;
  logic [SW-1:0] b_in_stamp = '0;
  logic b_in_ready, b_req_valid, b_req_done;
  logic [SW-1:0] b_req_stamps;
  logic [0:0] b_req_lane_mask;

  vx_raster_stamp_packer #(.NUM_LANES(NL), .STAMP_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_stamp(in_stamp), .in_last(in_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_stamps(req_stamps),
    .req_lane_mask(req_lane_mask), .req_done(req_done)
  );

  vx_raster_stamp_packer #(.NUM_LANES(1), .STAMP_W(SW)) dut1 (
    .clk(clk), .reset(reset), .start(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_stamp(b_in_stamp), .in_last(b_in_last),
    .req_valid(b_req_valid), .req_ready(1'b1), .req_stamps(b_req_stamps),
    .req_lane_mask(b_req_lane_mask), .req_done(b_req_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*SW-1:0] stamps;
    logic [NL-1:0]    mask;
    bit               last;
  } pkt_t;

  pkt_t          exp_q[$];
  logic [SW-1:0] mbuf[$];
  bit            model_done = 1'b0;
  bit            mon_en = 1'b0;
  logic          exp_rdy;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [SW-1:0] d, input bit last);
    pkt_t p;
    mbuf.push_back(d);
    if (mbuf.size() == NL || last) begin
      p.stamps = '0;
      p.mask   = '0;
      foreach (mbuf[i]) begin
        p.stamps[i*SW +: SW] = mbuf[i];
        p.mask[i] = 1'b1;
      end
      p.last = last;
      exp_q.push_back(p);
      mbuf.delete();
    end
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the stamp.
  task automatic send(input logic [SW-1:0] d, input bit last);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_stamp = d;
    in_last  = last;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    else model_accept(d, last);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!model_done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!model_done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_done = 1'b0;
  endtask

  // Scoreboard monitor: compares the request port every cycle, popping on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rdy = !model_done &&
                (!((mbuf.size() == NL-1) || in_last) || exp_q.size() == 0 || req_ready);
      chk("in_ready", in_ready, exp_rdy);
      if (model_done) begin
        chk("done_valid", req_valid, 1'b1);
        chk("done_flag", req_done, 1'b1);
        chk("done_mask", req_lane_mask, '0);
        chk("done_stamps", req_stamps, '0);
      end else if (exp_q.size() != 0) begin
        chk("pkt_valid", req_valid, 1'b1);
        chk("pkt_done", req_done, 1'b0);
        chk("pkt_mask", req_lane_mask, exp_q[0].mask);
        chk("pkt_stamps", req_stamps, exp_q[0].stamps);
        if (req_ready) begin
          if (exp_q[0].last) model_done = 1'b1;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_valid", req_valid, 1'b0);
        chk("idle_done", req_done, 1'b0);
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_mask", req_lane_mask, '0);
    chk("rst_done", req_done, 1'b0);
    chk("rst_stamps", req_stamps, '0);
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Two full packets, then done packets on every cycle.
    for (int k = 1; k <= 8; k++) send(SW'(k), k == 8);
    wait_done();
    repeat (3) begin @(posedge clk); #1; end
    pulse_start();

    // Partial flush and single-lane packet.
    for (int k = 1; k <= 6; k++) send(SW'(k), k == 6);
    wait_done();
    pulse_start();
    send(16'h0042, 1'b1);
    wait_done();
    pulse_start();

    // Back-pressure window during a 12-stamp stream.
    fork
      for (int k = 1; k <= 12; k++) send(SW'(16'h10 + k), k == 12);
      begin
        repeat (2) begin @(posedge clk); #1; end
        req_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        req_ready = 1'b1;
      end
    join
    wait_done();
    pulse_start();

    // start while running must be ignored.
    send(16'h0021, 1'b0);
    send(16'h0022, 1'b0);
    pulse_start();
    send(16'h0023, 1'b0);
    send(16'h0024, 1'b1);
    wait_done();
    pulse_start();

    // Asynchronous reset with a pending packet and two buffered stamps.
    req_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(SW'(16'h30 + k), 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_req_valid", req_valid, 1'b0);
    chk("arst_mask", req_lane_mask, '0);
    chk("arst_done", req_done, 1'b0);
    chk("arst_stamps", req_stamps, '0);
    exp_q.delete();
    mbuf.delete();
    model_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    req_ready = 1'b1;
    for (int k = 1; k <= 4; k++) send(SW'(16'h40 + k), k == 4);
    wait_done();

    // Single-lane instance: every stamp is its own packet.
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      b_in_valid = 1'b1;
      b_in_stamp = SW'(16'h100 + k);
      b_in_last  = (k == 3);
      @(negedge clk);
      chk("l1_in_ready", b_in_ready, 1'b1);
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      @(negedge clk);
      chk("l1_valid", b_req_valid, 1'b1);
      chk("l1_mask", b_req_lane_mask, 1'b1);
      chk("l1_stamps", b_req_stamps, SW'(16'h100 + k));
      chk("l1_done", b_req_done, 1'b0);
    end
    @(negedge clk);
    chk("l1_final_done", b_req_done, 1'b1);
    chk("l1_final_valid", b_req_valid, 1'b1);
    chk("l1_final_ready", b_in_ready, 1'b0);
    chk("l1_final_mask", b_req_lane_mask, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
